// File: rtl/dt_pass_if.sv
// Control and memory-port bundle for the distance-transform pass engine.
// master = engine side, slave = controller/memory side.
interface dt_pass_if #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8
);
  localparam int AW = $clog2(IMG_W * IMG_H);

  logic             start;
  logic             dir;
  logic             mem_ready;
  logic [PIX_W-1:0] rd_data;
  logic             mem_rd;
  logic             mem_wr;
  logic [AW-1:0]    mem_addr;
  logic [PIX_W-1:0] wr_data;
  logic             busy;
  logic             done;

  modport master (
    input  start, dir, mem_ready, rd_data,
    output mem_rd, mem_wr, mem_addr, wr_data, busy, done
  );

  modport slave (
    output start, dir, mem_ready, rd_data,
    input  mem_rd, mem_wr, mem_addr, wr_data, busy, done
  );
endinterface

// File: rtl/dt_pass.sv
// One chamfer distance-transform pass (forward or backward) over the image interior; DT_SAT_EN makes min+1 saturate instead of wrap.
// Object pixel: centre read, 4 pipelined neighbour reads, 1 write; mem_ready=0 freezes all state except capture of the read already in flight.
module dt_pass #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  dt_pass_if.master bus
);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam logic [AW-1:0] C_ONE  = AW'(1);
  localparam logic [AW-1:0] C_XMAX = AW'(IMG_W - 2);
  localparam logic [AW-1:0] C_YMAX = AW'(IMG_H - 2);
  localparam logic [AW-1:0] C_W    = AW'(IMG_W);

  typedef enum logic [2:0] {S_IDLE, S_CENTRE, S_NBR, S_WRITE, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_dir;
  logic             r_rpend;
  logic [AW-1:0]    r_x, r_y;
  logic [2:0]       r_k;
  logic [PIX_W-1:0] r_min, r_centre;

  logic             w_last, w_adv, w_start;
  logic [AW-1:0]    w_nx, w_ny, w_caddr, w_naddr, w_nbr_addr;
  logic [PIX_W:0]   w_sum, w_pre;
  logic [PIX_W-1:0] w_res, w_rmin;

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (!r_dir) begin
      w_last = (r_x == C_XMAX) && (r_y == C_YMAX);
      if (r_x == C_XMAX) begin
        w_nx = C_ONE;
        w_ny = r_y + C_ONE;
      end else begin
        w_nx = r_x + C_ONE;
      end
    end else begin
      w_last = (r_x == C_ONE) && (r_y == C_ONE);
      if (r_x == C_ONE) begin
        w_nx = C_XMAX;
        w_ny = r_y - C_ONE;
      end else begin
        w_nx = r_x - C_ONE;
      end
    end
  end

  assign w_caddr = r_y * C_W + r_x;
  assign w_naddr = w_ny * C_W + w_nx;

  // Forward visits NW,N,NE,W; backward mirrors through the centre to SE,S,SW,E.
  always_comb begin
    w_nbr_addr = w_caddr;
    unique case ({r_dir, r_k[1:0]})
      3'b000: w_nbr_addr = w_caddr - C_W - C_ONE;
      3'b001: w_nbr_addr = w_caddr - C_W;
      3'b010: w_nbr_addr = w_caddr - C_W + C_ONE;
      3'b011: w_nbr_addr = w_caddr - C_ONE;
      3'b100: w_nbr_addr = w_caddr + C_W + C_ONE;
      3'b101: w_nbr_addr = w_caddr + C_W;
      3'b110: w_nbr_addr = w_caddr + C_W - C_ONE;
      default: w_nbr_addr = w_caddr + C_ONE;
    endcase
  end

  assign w_rmin = (bus.rd_data < r_min) ? bus.rd_data : r_min;
  assign w_sum  = {1'b0, r_min} + {{PIX_W{1'b0}}, 1'b1};
  assign w_pre  = (r_dir && ({1'b0, r_centre} < w_sum)) ? {1'b0, r_centre} : w_sum;
`ifdef DT_SAT_EN
  assign w_res  = w_pre[PIX_W] ? {PIX_W{1'b1}} : w_pre[PIX_W-1:0];
`else
  assign w_res  = w_pre[PIX_W-1:0];
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_adv        = 1'b0;
    w_start      = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_addr = '0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_start     = 1'b1;
          w_state_nxt = S_CENTRE;
        end
      end
      S_CENTRE: begin
        if (!r_rpend) begin
          bus.mem_addr = w_caddr;
          bus.mem_rd   = bus.mem_ready;
        end else if (bus.rd_data != '0) begin
          bus.mem_addr = w_caddr;
          w_state_nxt  = S_NBR;
        end else if (w_last) begin
          bus.mem_addr = w_caddr;
          w_state_nxt  = S_DONE;
        end else begin
          // Background: step on and overlap the next centre read with this capture.
          w_adv        = 1'b1;
          bus.mem_addr = w_naddr;
          bus.mem_rd   = bus.mem_ready;
        end
      end
      S_NBR: begin
        if (r_k[2]) begin
          bus.mem_addr = w_caddr;
          if (r_rpend) w_state_nxt = S_WRITE;
        end else begin
          bus.mem_addr = w_nbr_addr;
          bus.mem_rd   = bus.mem_ready;
        end
      end
      S_WRITE: begin
        bus.mem_addr = w_caddr;
        bus.mem_wr   = bus.mem_ready;
        if (bus.mem_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = S_CENTRE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy    = (r_state == S_CENTRE) || (r_state == S_NBR) || (r_state == S_WRITE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.wr_data = (r_state == S_WRITE) ? w_res : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_rpend  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_min    <= '0;
      r_centre <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rpend <= bus.mem_rd;
      if (w_start) begin
        r_dir <= bus.dir;
        r_x   <= bus.dir ? C_XMAX : C_ONE;
        r_y   <= bus.dir ? C_YMAX : C_ONE;
      end else if (w_adv) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
      if ((r_state == S_CENTRE) && r_rpend) begin
        r_centre <= bus.rd_data;
        r_k      <= '0;
        r_min    <= '1;
      end
      if (r_state == S_NBR) begin
        if (bus.mem_rd) r_k <= r_k + 3'd1;
        if (r_rpend) r_min <= w_rmin;
      end
    end
  end
endmodule

// File: tb/tb_dt_pass.sv
// Bench for dt_pass on an 8x8 image with a behavioural memory and a raster-loop reference model.
module tb_dt_pass;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = 8;
  localparam int N  = W * H;
`ifdef DT_SAT_EN
  localparam int EXP_FULL = 255;
`else
  localparam int EXP_FULL = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dt_pass_if #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) bus ();
  dt_pass #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] mem [N];
  logic [7:0] ref_img [N];
  int cyc = 0, ready_mode = 0, stall_from = 0, stall_len = 0, bad_strobes = 0;
  int start_cyc = 0, done_cyc = 0;
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_dat_q[$], wr_cyc_q[$];
  int exp_addr_q[$], exp_dat_q[$];
  int vectors = 0, miscompares = 0;

  typedef struct {
    bit dir;
    int c;
    int n0, n1, n2, n3;
    int exp_wr;
    int exp_dat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Memory: read data appears the cycle after an accepted read, junk otherwise.
  initial begin
    bit pend;
    int paddr;
    pend = 0;
    paddr = 0;
    bus.rd_data = '0;
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.rd_data = pend ? mem[paddr] : 8'($urandom);
      case (ready_mode)
        1: bus.mem_ready = ($urandom_range(0, 9) < 7);
        2: bus.mem_ready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
        default: bus.mem_ready = 1'b1;
      endcase
      @(negedge clk);
      pend = 0;
      if (reset || !bus.mem_ready) begin
        if (bus.mem_rd || bus.mem_wr) bad_strobes++;
      end else begin
        if (bus.mem_rd) begin
          pend = 1;
          paddr = int'(bus.mem_addr);
          rd_addr_q.push_back(paddr);
          rd_cyc_q.push_back(cyc);
        end
        if (bus.mem_wr) begin
          mem[bus.mem_addr] = bus.wr_data;
          wr_addr_q.push_back(int'(bus.mem_addr));
          wr_dat_q.push_back(int'(bus.wr_data));
          wr_cyc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  // Reference pass: walk interior pixels by raster index, updating ref_img in place.
  task automatic model_run(input bit d);
    int idx, x, y, p, m, s;
    exp_addr_q.delete();
    exp_dat_q.delete();
    for (int k = 0; k < (W - 2) * (H - 2); k++) begin
      idx = d ? (W - 2) * (H - 2) - 1 - k : k;
      x = 1 + idx % (W - 2);
      y = 1 + idx / (W - 2);
      p = y * W + x;
      if (ref_img[p] != 0) begin
        if (!d) m = min4(ref_img[p-W-1], ref_img[p-W], ref_img[p-W+1], ref_img[p-1]);
        else    m = min4(ref_img[p+W+1], ref_img[p+W], ref_img[p+W-1], ref_img[p+1]);
        s = m + 1;
        if (d && int'(ref_img[p]) < s) s = ref_img[p];
`ifdef DT_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        ref_img[p] = 8'(s);
        exp_addr_q.push_back(p);
        exp_dat_q.push_back(s);
      end
    end
  endtask

  task automatic start_pass(input bit d);
    @(posedge clk);
    #2;
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    start_cyc = cyc;
    bus.start = 1'b1;
    bus.dir = d;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_done(input bit d, input bit poke);
    bit seen;
    seen = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (poke && k == 20) begin
        bus.start = 1'b1;
        bus.dir = !d;
      end else if (poke && k == 21) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1;
        done_cyc = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    check("done_reached", int'(seen), 1);
    check("busy_in_done", int'(bus.busy), 0);
  endtask

  task automatic cmp_writes(input string tag);
    int diff, border, x, y;
    check($sformatf("%s wr_count", tag), wr_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s wr%0d addr", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s wr%0d data", tag, i), wr_dat_q[i], exp_dat_q[i]);
    end
    diff = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_img[i]) diff++;
    check($sformatf("%s image_diff", tag), diff, 0);
    border = 0;
    foreach (wr_addr_q[i]) begin
      x = wr_addr_q[i] % W;
      y = wr_addr_q[i] / W;
      if (x == 0 || y == 0 || x == W - 1 || y == H - 1) border++;
    end
    check($sformatf("%s border_writes", tag), border, 0);
  endtask

  task automatic load_ones();
    for (int i = 0; i < N; i++) begin
      ref_img[i] = ((i % W) == 0 || (i / W) == 0 || (i % W) == W - 1 || (i / W) == H - 1) ? 8'd0 : 8'd1;
      mem[i] = ref_img[i];
    end
  endtask

  initial begin
    vec_t tv[11];
    int p, i36, c28, base_lat, rdiff;
    int rd1[$];
    bit found;

    tv[0]  = '{0, 5,   3,   7,   9,   4,   1, 4};
    tv[1]  = '{0, 1,   0,   9,   9,   9,   1, 1};
    tv[2]  = '{0, 200, 10,  20,  30,  40,  1, 11};
    tv[3]  = '{0, 9,   255, 255, 255, 255, 1, EXP_FULL};
    tv[4]  = '{0, 3,   254, 254, 254, 254, 1, 255};
    tv[5]  = '{0, 0,   5,   5,   5,   5,   0, 0};
    tv[6]  = '{1, 5,   3,   7,   9,   4,   1, 4};
    tv[7]  = '{1, 2,   9,   9,   9,   9,   1, 2};
    tv[8]  = '{1, 200, 100, 50,  60,  70,  1, 51};
    tv[9]  = '{1, 7,   255, 255, 255, 255, 1, 7};
    tv[10] = '{1, 1,   0,   0,   0,   0,   1, 1};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.dir = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_rd", int'(bus.mem_rd), 0);
    check("rst mem_wr", int'(bus.mem_wr), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst mem_addr", int'(bus.mem_addr), 0);
    check("rst wr_data", int'(bus.wr_data), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single object pixel whose neighbours are all border pixels, so the result is known by hand.
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < N; i++) mem[i] = '0;
      p = tv[v].dir ? 6 * W + 6 : W + 1;
      mem[p] = 8'(tv[v].c);
      if (!tv[v].dir) begin
        mem[p-W-1] = 8'(tv[v].n0); mem[p-W] = 8'(tv[v].n1);
        mem[p-W+1] = 8'(tv[v].n2); mem[p-1] = 8'(tv[v].n3);
      end else begin
        mem[p+W+1] = 8'(tv[v].n0); mem[p+W] = 8'(tv[v].n1);
        mem[p+W-1] = 8'(tv[v].n2); mem[p+1] = 8'(tv[v].n3);
      end
      ready_mode = 0;
      start_pass(tv[v].dir);
      wait_done(tv[v].dir, 0);
      check($sformatf("vec%0d wr_count", v), wr_addr_q.size(), tv[v].exp_wr);
      check($sformatf("vec%0d rd_count", v), rd_addr_q.size(), 36 + 4 * tv[v].exp_wr);
      if (wr_addr_q.size() > 0) begin
        check($sformatf("vec%0d wr_addr", v), wr_addr_q[0], p);
        check($sformatf("vec%0d wr_data", v), wr_dat_q[0], tv[v].exp_dat);
      end
    end

    // Solid interior, forward then backward.
    load_ones();
    model_run(0);
    start_pass(0);
    wait_done(0, 0);
    cmp_writes("ones_fwd");
    check("ones_fwd (1,1)", wr_dat_q[0], 1);
    check("ones_fwd (2,2)", wr_dat_q[7], 2);
    check("ones_fwd (3,3)", wr_dat_q[14], 3);
    check("ones_fwd done_latency", done_cyc, wr_cyc_q[wr_cyc_q.size() - 1] + 1);
    model_run(1);
    start_pass(1);
    wait_done(1, 0);
    cmp_writes("ones_bwd");
    check("ones_bwd (6,6) addr", wr_addr_q[0], 54);
    check("ones_bwd (6,6) data", wr_dat_q[0], 1);

    // Lone pixel at (4,4): exact read order, then the same with a 3-cycle stall mid-neighbour reads.
    for (int i = 0; i < N; i++) begin mem[i] = '0; ref_img[i] = '0; end
    mem[36] = 8'd1; ref_img[36] = 8'd1;
    model_run(0);
    start_pass(0);
    wait_done(0, 0);
    cmp_writes("lone");
    check("lone rd_count", rd_addr_q.size(), 40);
    i36 = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] == 36 && i36 == 0) i36 = i;
    check("lone rd NW", rd_addr_q[i36 + 1], 27);
    check("lone rd N", rd_addr_q[i36 + 2], 28);
    check("lone rd NE", rd_addr_q[i36 + 3], 29);
    check("lone rd W", rd_addr_q[i36 + 4], 35);
    c28 = rd_cyc_q[i36 + 2] - start_cyc;
    base_lat = wr_cyc_q[0] - start_cyc;
    rd1 = rd_addr_q;

    for (int i = 0; i < N; i++) begin mem[i] = '0; ref_img[i] = '0; end
    mem[36] = 8'd1; ref_img[36] = 8'd1;
    model_run(0);
    start_pass(0);
    stall_from = start_cyc + c28;
    stall_len = 3;
    ready_mode = 2;
    wait_done(0, 0);
    ready_mode = 0;
    cmp_writes("stall");
    rdiff = (rd_addr_q.size() == rd1.size()) ? 0 : 1;
    foreach (rd1[i]) if (i < rd_addr_q.size() && rd_addr_q[i] != rd1[i]) rdiff++;
    check("stall rd_sequence_diff", rdiff, 0);
    check("stall wr_latency", wr_cyc_q[0] - start_cyc, base_lat + 3);
    check("stall no_strobe_while_low", bad_strobes, 0);

    // Randomized images, directions and grants against the reference model.
    for (int it = 0; it < 6; it++) begin
      bit d;
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        ref_img[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        mem[i] = ref_img[i];
      end
      model_run(d);
      ready_mode = 1;
      start_pass(d);
      wait_done(d, it == 2);
      ready_mode = 0;
      cmp_writes($sformatf("rand%0d", it));
    end

    // Reset while a write is being presented, then a clean rerun.
    load_ones();
    start_pass(0);
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.mem_wr && wr_addr_q.size() >= 4) begin found = 1; break; end
    end
    check("rstmid write_seen", int'(found), 1);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid mem_wr", int'(bus.mem_wr), 0);
    check("rstmid wr_data", int'(bus.wr_data), 0);
    check("rstmid mem_addr", int'(bus.mem_addr), 0);
    @(posedge clk);
    #1;
    check("rstmid busy", int'(bus.busy), 0);
    check("rstmid done", int'(bus.done), 0);
    check("rstmid mem_rd", int'(bus.mem_rd), 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    load_ones();
    model_run(0);
    start_pass(0);
    wait_done(0, 0);
    cmp_writes("rstmid_rerun");
    check("final no_strobe_while_low", bad_strobes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
